// File: rtl/regfile_param_if.sv
// Decode/writeback-facing bundle of the parametrised register file.
// The master side drives addresses, write data, reservations and clear; the slave side returns read data and status.
interface regfile_param_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  ctrl_writeEnable;
   logic [ADDR_WIDTH-1:0] ctrl_writeReg;
   logic [DATA_WIDTH-1:0] data_writeReg;
   logic [ADDR_WIDTH-1:0] ctrl_readRegA;
   logic [ADDR_WIDTH-1:0] ctrl_readRegB;
   logic [DATA_WIDTH-1:0] data_readRegA;
   logic [DATA_WIDTH-1:0] data_readRegB;
   logic                  ctrl_reserveEnable;
   logic [ADDR_WIDTH-1:0] ctrl_reserveReg;
   logic                  pending_readRegA;
   logic                  pending_readRegB;
   logic                  ctrl_clear;
   logic                  clear_busy;

   modport master (
      output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      output ctrl_readRegA, ctrl_readRegB,
      output ctrl_reserveEnable, ctrl_reserveReg, ctrl_clear,
      input  data_readRegA, data_readRegB,
      input  pending_readRegA, pending_readRegB, clear_busy
   );

   modport slave (
      input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      input  ctrl_readRegA, ctrl_readRegB,
      input  ctrl_reserveEnable, ctrl_reserveReg, ctrl_clear,
      output data_readRegA, data_readRegB,
      output pending_readRegA, pending_readRegB, clear_busy
   );
endinterface

// File: rtl/regfile_param.sv
// Two-read/one-write register file with write-to-read bypass, per-entry pending scoreboard
// and a sequential clear engine that walks every entry once.
//
// state   | meaning
// S_IDLE  | normal operation: writes, reservations, bypass, clear request sampled
// S_CLEAR | zeroing entry clr_idx each cycle; external writes/reservations dropped
module regfile_param #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int BYPASS     = 1,
   parameter int ZERO_REG   = 1
) (
   input logic            clock,
   input logic            ctrl_reset,
   regfile_param_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]      pend_q;

   logic                  idle;
   logic                  wr_eff;
   logic                  rsv_eff;
   logic [DATA_WIDTH-1:0] rd_a;
   logic [DATA_WIDTH-1:0] rd_b;

   assign idle = (state_q == S_IDLE);

   // Reset gates the bypass so reads show zero for as long as reset is held.
   assign wr_eff  = idle && !ctrl_reset && bus.ctrl_writeEnable &&
                    ((ZERO_REG == 0) || (bus.ctrl_writeReg != '0));
   assign rsv_eff = idle && bus.ctrl_reserveEnable &&
                    ((ZERO_REG == 0) || (bus.ctrl_reserveReg != '0));

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      case (state_q)
         S_IDLE: begin
            if (bus.ctrl_clear) begin
               state_d   = S_CLEAR;
               clr_idx_d = '0;
            end
         end
         S_CLEAR: begin
            clr_idx_d = clr_idx_q + ADDR_WIDTH'(1);
            if (&clr_idx_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         state_q   <= S_IDLE;
         clr_idx_q <= '0;
         pend_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         if (state_q == S_CLEAR) begin
            mem_q[clr_idx_q]  <= '0;
            pend_q[clr_idx_q] <= 1'b0;
         end else begin
            if (wr_eff) begin
               mem_q[bus.ctrl_writeReg]  <= bus.data_writeReg;
               pend_q[bus.ctrl_writeReg] <= 1'b0;
            end
            // Applied after the write so a same-cycle reserve leaves the entry pending.
            if (rsv_eff) pend_q[bus.ctrl_reserveReg] <= 1'b1;
         end
      end
   end

   always_comb begin
      rd_a = mem_q[bus.ctrl_readRegA];
      if ((ZERO_REG != 0) && (bus.ctrl_readRegA == '0)) rd_a = '0;
      if ((BYPASS != 0) && wr_eff && (bus.ctrl_writeReg == bus.ctrl_readRegA)) rd_a = bus.data_writeReg;
   end

   always_comb begin
      rd_b = mem_q[bus.ctrl_readRegB];
      if ((ZERO_REG != 0) && (bus.ctrl_readRegB == '0)) rd_b = '0;
      if ((BYPASS != 0) && wr_eff && (bus.ctrl_writeReg == bus.ctrl_readRegB)) rd_b = bus.data_writeReg;
   end

   assign bus.data_readRegA    = rd_a;
   assign bus.data_readRegB    = rd_b;
   assign bus.pending_readRegA = pend_q[bus.ctrl_readRegA];
   assign bus.pending_readRegB = pend_q[bus.ctrl_readRegB];
   assign bus.clear_busy       = (state_q == S_CLEAR);
endmodule
